// File: rtl/xif_apu_pkg.sv
// Shared types and constants for the X-interface to APU offload bridge.
package xif_apu_pkg;

    localparam logic [6:0] OPCODE_V_DEF = 7'h57;
    localparam logic [2:0] FUNCT3_CFG   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_COMMIT,
        ST_REQ,
        ST_EXEC,
        ST_RESP
    } state_e;

    // Packed so that instr sits in [31:0], rs0 in [63:32] and rs1 in [95:64].
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs0;
        logic [31:0] instr;
    } apu_operands_t;

endpackage

// File: rtl/xif_apu_bridge.sv
// Offloads one X-interface instruction at a time to an APU and returns its result.
// Optional XIF_APU_BRIDGE_CYCLE_CNT_EN adds exec_cycles_o (REQ entry to RESP entry).
module xif_apu_bridge
    import xif_apu_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter logic [6:0]  OPCODE_V   = OPCODE_V_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]           issue_rs0_i,
    input  logic [31:0]           issue_rs1_i,
    input  logic [1:0]            issue_rs_valid_i,
    output logic                  issue_accept_o,
    output logic                  issue_writeback_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  apu_req_o,
    input  logic                  apu_gnt_i,
    output logic [5:0]            apu_op_o,
    output logic [95:0]           apu_operands_o,
    input  logic                  apu_rvalid_i,
    input  logic [31:0]           apu_result_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [31:0]           result_data_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o
`ifdef XIF_APU_BRIDGE_CYCLE_CNT_EN
    ,
    output logic [15:0]           exec_cycles_o
`endif
);

    state_e                state_q, state_d;
    logic [31:0]           instr_q, rs0_q, rs1_q, result_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic                  latch_en, cap_en;
    apu_operands_t         ops;

    // Reset gates ready so the core never sees a handshake while held in reset.
    assign issue_ready_o     = rst_ni && (state_q == ST_IDLE) && (issue_rs_valid_i == 2'b11);
    assign issue_accept_o    = (issue_instr_i[6:0] == OPCODE_V);
    assign issue_writeback_o = issue_accept_o && (issue_instr_i[14:12] == FUNCT3_CFG);

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        cap_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (issue_valid_i && issue_ready_o && issue_accept_o) begin
                    latch_en = 1'b1;
                    // A commit arriving with the issue is resolved without a WAIT_COMMIT stop.
                    if (commit_valid_i && (commit_id_i == issue_id_i)) begin
                        state_d = commit_kill_i ? ST_IDLE : ST_REQ;
                    end else begin
                        state_d = ST_WAIT_COMMIT;
                    end
                end
            end
            ST_WAIT_COMMIT: begin
                if (commit_valid_i && (commit_id_i == id_q)) begin
                    state_d = commit_kill_i ? ST_IDLE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (apu_gnt_i) begin
                    if (apu_rvalid_i) begin
                        cap_en  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (apu_rvalid_i) begin
                    cap_en  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (result_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                instr_q <= issue_instr_i;
                rs0_q   <= issue_rs0_i;
                rs1_q   <= issue_rs1_i;
                id_q    <= issue_id_i;
            end
            if (cap_en) result_q <= apu_result_i;
        end
    end

    always_comb begin
        ops       = '0;
        ops.instr = instr_q;
        ops.rs0   = rs0_q;
        ops.rs1   = rs1_q;
    end

    assign apu_req_o      = (state_q == ST_REQ);
    assign apu_op_o       = instr_q[31:26];
    assign apu_operands_o = ops;

    assign result_valid_o = (state_q == ST_RESP);
    assign result_id_o    = id_q;
    assign result_data_o  = result_q;
    assign result_rd_o    = instr_q[11:7];
    assign result_we_o    = (instr_q[14:12] == FUNCT3_CFG);

`ifdef XIF_APU_BRIDGE_CYCLE_CNT_EN
    logic [15:0] cyc_q, cyc_inc, exec_cycles_q;

    // cyc_q holds the number of completed REQ/EXEC cycles; the +1 on RESP entry counts the last one.
    assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q         <= '0;
            exec_cycles_q <= '0;
        end else begin
            if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
                cyc_q <= '0;
            end else if ((state_q == ST_REQ) || (state_q == ST_EXEC)) begin
                cyc_q <= cyc_inc;
            end
            if ((state_d == ST_RESP) && (state_q != ST_RESP)) exec_cycles_q <= cyc_inc;
        end
    end

    assign exec_cycles_o = exec_cycles_q;
`endif

endmodule

// File: tb/tb_xif_apu_bridge.sv
// Randomized self-checking bench for xif_apu_bridge against a transaction-level model.
module tb_xif_apu_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i, issue_ready_o;
    logic [31:0] issue_instr_i, issue_rs0_i, issue_rs1_i;
    logic [3:0]  issue_id_i;
    logic [1:0]  issue_rs_valid_i;
    logic        issue_accept_o, issue_writeback_o;
    logic        commit_valid_i, commit_kill_i;
    logic [3:0]  commit_id_i;
    logic        apu_req_o, apu_gnt_i, apu_rvalid_i;
    logic [5:0]  apu_op_o;
    logic [95:0] apu_operands_o;
    logic [31:0] apu_result_i;
    logic        result_valid_o, result_ready_i, result_we_o;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
`ifdef XIF_APU_BRIDGE_CYCLE_CNT_EN
    logic [15:0] exec_cycles_o;
`endif

    int n_chk = 0;
    int n_pass = 0;

    xif_apu_bridge #(.X_ID_WIDTH(4), .OPCODE_V(7'h57)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_op_o(apu_op_o),
        .apu_operands_o(apu_operands_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o)
`ifdef XIF_APU_BRIDGE_CYCLE_CNT_EN
        , .exec_cycles_o(exec_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        issue_valid_i = 0; issue_instr_i = '0; issue_id_i = '0;
        issue_rs0_i = '0; issue_rs1_i = '0; issue_rs_valid_i = 2'b11;
        commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0;
        apu_gnt_i = 0; apu_rvalid_i = 0; apu_result_i = '0; result_ready_i = 0;
        tick(); tick();
        n_chk++;
        if (issue_ready_o !== 1'b0 || apu_req_o !== 1'b0 || result_valid_o !== 1'b0) begin
            $display("FAIL reset_ctrl got rdy=%b req=%b rv=%b exp 0/0/0", issue_ready_o, apu_req_o, result_valid_o);
        end else n_pass++;
        n_chk++;
        if (result_data_o !== 32'h0 || result_id_o !== 4'h0 || apu_operands_o !== 96'h0) begin
            $display("FAIL reset_data got data=%h id=%h ops=%h exp 0", result_data_o, result_id_o, apu_operands_o);
        end else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_chk++;
        if (issue_ready_o !== 1'b1) begin
            $display("FAIL reset_release_ready got=%b exp=1", issue_ready_o);
        end else n_pass++;
        tick();
    endtask

    // One full offload scenario; expectations come from the transaction arguments only.
    task automatic test_txn(input logic [31:0] instr, input logic [3:0] id,
                            input logic [31:0] rs0, input logic [31:0] rs1,
                            input bit csame, input bit kill, input bit wrong,
                            input int gdly, input int rdly, input int ydly,
                            input logic [31:0] data, input string nm);
        bit acc, wb;
        int vcnt, exp_cyc;
        acc = (instr[6:0] == 7'h57);
        wb  = acc && (instr[14:12] == 3'b111);
        exp_cyc = gdly + 1 + rdly;
        if (exp_cyc > 65535) exp_cyc = 65535;
        issue_valid_i = 1; issue_instr_i = instr; issue_id_i = id;
        issue_rs0_i = rs0; issue_rs1_i = rs1; issue_rs_valid_i = 2'b11;
        commit_valid_i = csame; commit_id_i = id; commit_kill_i = kill;
        #1;
        n_chk++;
        if (issue_ready_o !== 1'b1 || issue_accept_o !== acc || issue_writeback_o !== wb) begin
            $display("FAIL %s issue got rdy=%b acc=%b wb=%b exp 1/%b/%b", nm, issue_ready_o, issue_accept_o, issue_writeback_o, acc, wb);
        end else n_pass++;
        tick();
        issue_valid_i = 0; commit_valid_i = 0; issue_instr_i = $urandom;
        if (!acc) begin
            tick();
            n_chk++;
            if (issue_ready_o !== 1'b1 || apu_req_o !== 1'b0) begin
                $display("FAIL %s reject got rdy=%b req=%b exp 1/0", nm, issue_ready_o, apu_req_o);
            end else n_pass++;
            return;
        end
        if (!csame) begin
            n_chk++;
            if (issue_ready_o !== 1'b0 || apu_req_o !== 1'b0) begin
                $display("FAIL %s wait_commit got rdy=%b req=%b exp 0/0", nm, issue_ready_o, apu_req_o);
            end else n_pass++;
            if (wrong) begin
                commit_valid_i = 1; commit_id_i = id ^ 4'd1; commit_kill_i = 0;
                tick();
                commit_valid_i = 0;
                n_chk++;
                if (issue_ready_o !== 1'b0 || apu_req_o !== 1'b0) begin
                    $display("FAIL %s wrong_id got rdy=%b req=%b exp 0/0", nm, issue_ready_o, apu_req_o);
                end else n_pass++;
            end
            commit_valid_i = 1; commit_id_i = id; commit_kill_i = kill;
            tick();
            commit_valid_i = 0;
        end
        if (kill) begin
            tick();
            n_chk++;
            if (issue_ready_o !== 1'b1 || apu_req_o !== 1'b0 || result_valid_o !== 1'b0) begin
                $display("FAIL %s killed got rdy=%b req=%b rv=%b exp 1/0/0", nm, issue_ready_o, apu_req_o, result_valid_o);
            end else n_pass++;
            return;
        end
        n_chk++;
        if (apu_req_o !== 1'b1 || apu_op_o !== instr[31:26] || apu_operands_o !== {rs1, rs0, instr}) begin
            $display("FAIL %s apu_req got req=%b op=%h ops=%h exp 1/%h/%h", nm, apu_req_o, apu_op_o, apu_operands_o, instr[31:26], {rs1, rs0, instr});
        end else n_pass++;
        repeat (gdly) tick();
        n_chk++;
        if (apu_req_o !== 1'b1 || apu_operands_o !== {rs1, rs0, instr}) begin
            $display("FAIL %s apu_hold got req=%b ops=%h exp 1/%h", nm, apu_req_o, apu_operands_o, {rs1, rs0, instr});
        end else n_pass++;
        apu_gnt_i = 1; apu_rvalid_i = (rdly == 0); apu_result_i = (rdly == 0) ? data : $urandom;
        tick();
        apu_gnt_i = 0; apu_rvalid_i = 0; apu_result_i = $urandom;
        if (rdly > 0) begin
            n_chk++;
            if (apu_req_o !== 1'b0 || result_valid_o !== 1'b0) begin
                $display("FAIL %s exec got req=%b rv=%b exp 0/0", nm, apu_req_o, result_valid_o);
            end else n_pass++;
            repeat (rdly - 1) tick();
            apu_rvalid_i = 1; apu_result_i = data;
            tick();
            apu_rvalid_i = 0; apu_result_i = $urandom;
        end
        vcnt = 0;
        result_ready_i = 0;
        for (int c = 0; c < ydly; c++) begin
            if (result_valid_o === 1'b1 && result_data_o === data && result_id_o === id) vcnt++;
            tick();
        end
        result_ready_i = 1;
        #1;
        if (result_valid_o === 1'b1 && result_data_o === data && result_id_o === id) vcnt++;
        n_chk++;
        if (result_id_o !== id || result_data_o !== data || result_rd_o !== instr[11:7] || result_we_o !== wb) begin
            $display("FAIL %s result got id=%h data=%h rd=%h we=%b exp %h/%h/%h/%b", nm, result_id_o, result_data_o, result_rd_o, result_we_o, id, data, instr[11:7], wb);
        end else n_pass++;
        n_chk++;
        if (vcnt !== ydly + 1) begin
            $display("FAIL %s result_hold got %0d stable valid cycles exp %0d", nm, vcnt, ydly + 1);
        end else n_pass++;
`ifdef XIF_APU_BRIDGE_CYCLE_CNT_EN
        n_chk++;
        if (exec_cycles_o !== exp_cyc[15:0]) begin
            $display("FAIL %s exec_cycles got %0d exp %0d", nm, exec_cycles_o, exp_cyc);
        end else n_pass++;
`endif
        tick();
        result_ready_i = 0;
        n_chk++;
        if (result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin
            $display("FAIL %s back_idle got rv=%b rdy=%b exp 0/1", nm, result_valid_o, issue_ready_o);
        end else n_pass++;
    endtask

    task automatic test_reset_exec();
        issue_valid_i = 1; issue_instr_i = 32'h1400_7057; issue_id_i = 4'd9;
        issue_rs0_i = $urandom; issue_rs1_i = $urandom; issue_rs_valid_i = 2'b11;
        commit_valid_i = 1; commit_id_i = 4'd9; commit_kill_i = 0;
        tick();
        issue_valid_i = 0; commit_valid_i = 0;
        apu_gnt_i = 1;
        tick();
        apu_gnt_i = 0;
        rst_ni = 1'b0;
        #1;
        n_chk++;
        if (issue_ready_o !== 1'b0 || apu_req_o !== 1'b0 || result_valid_o !== 1'b0 ||
            apu_operands_o !== 96'h0 || result_id_o !== 4'h0 || apu_op_o !== 6'h0) begin
            $display("FAIL reset_exec got rdy=%b req=%b rv=%b ops=%h id=%h exp all 0", issue_ready_o, apu_req_o, result_valid_o, apu_operands_o, result_id_o);
        end else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        apu_rvalid_i = 1; apu_result_i = 32'hCAFE_F00D;
        tick();
        apu_rvalid_i = 0;
        tick();
        n_chk++;
        if (result_valid_o !== 1'b0 || apu_req_o !== 1'b0 || issue_ready_o !== 1'b1 || result_data_o !== 32'h0) begin
            $display("FAIL late_rvalid got rv=%b req=%b rdy=%b data=%h exp 0/0/1/0", result_valid_o, apu_req_o, issue_ready_o, result_data_o);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] instr;
        for (int i = 0; i < 30; i++) begin
            instr = $urandom;
            if ($urandom_range(3) != 0) instr[6:0] = 7'h57;
            test_txn(instr, 4'($urandom), $urandom, $urandom,
                     bit'($urandom_range(1)), ($urandom_range(4) == 0), bit'($urandom_range(1)),
                     int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
                     $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_txn(32'h0000_7057, 4'd3, 32'h1111_2222, 32'h3333_4444, 0, 0, 0, 2, 3, 0, 32'hDEAD_BEEF, "basic");
        test_txn(32'h0000_7033, 4'd2, $urandom, $urandom, 0, 0, 0, 0, 0, 0, $urandom, "reject");
        test_txn(32'h8000_0057, 4'd5, $urandom, $urandom, 0, 1, 1, 0, 0, 0, $urandom, "kill");
        test_txn(32'h0000_0057, 4'd7, $urandom, $urandom, 1, 1, 0, 0, 0, 0, $urandom, "kill_same");
        test_txn(32'hFC00_5FD7, 4'd6, $urandom, $urandom, 1, 0, 0, 0, 0, 4, 32'h0BAD_F00D, "same_cycle_hold");
        test_txn(32'h0000_7057, 4'd1, $urandom, $urandom, 0, 0, 1, 1, 1, 1, 32'h1234_5678, "wrong_id");
        test_reset_exec();
        test_random();
`ifdef XIF_APU_BRIDGE_CYCLE_CNT_EN
        test_txn(32'h0000_7057, 4'd4, $urandom, $urandom, 1, 0, 0, 70000, 1, 0, 32'h5A5A_5A5A, "cnt_sat");
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
